// File: rtl/matmul_seq_pkg.sv
// Shared types, saturation bounds and the clamp helpers for the matmul tile sequencer.
// The MATMUL_SAT_EN build macro selects saturating versus wrapping accumulation.
package matmul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ACC_W = 64;
  localparam int SAT_W = 32;

  typedef logic signed [ACC_W-1:0] elem_t;

  localparam elem_t SAT_MAX = {{(ACC_W-SAT_W+1){1'b0}}, {(SAT_W-1){1'b1}}};
  localparam elem_t SAT_MIN = {{(ACC_W-SAT_W+1){1'b1}}, {(SAT_W-1){1'b0}}};

  function automatic logic out_of_range(input elem_t x);
    return (x > SAT_MAX) || (x < SAT_MIN);
  endfunction

  function automatic elem_t clamp(input elem_t x);
    elem_t y;
    if (x > SAT_MAX) begin
      y = SAT_MAX;
    end else if (x < SAT_MIN) begin
      y = SAT_MIN;
    end else begin
      y = x;
    end
    return y;
  endfunction

endpackage

// File: rtl/matmul_sat_clamp.sv
// Per-element clamp of a datapath result to the signed SAT_W range, plus out-of-range flag.
// With MATMUL_SAT_EN undefined the value passes through and only the flag is reported.
module matmul_sat_clamp
  import matmul_seq_pkg::*;
(
  input  elem_t x,
  output elem_t y,
  output logic  flag
);

  // Range check always reported; correction only in the saturating build
  always_comb begin
    flag = out_of_range(x);
`ifdef MATMUL_SAT_EN
    y = clamp(x);
`else
    y = x;
`endif
  end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Walks a long-K multiply-accumulate through the fixed-depth datapath one K-tile at a time.
// Build macro MATMUL_SAT_EN: defined = saturating accumulate, undefined = wrap and report.
module matmul_tile_sequencer
  import matmul_seq_pkg::*;
#(
  parameter int M   = 2,
  parameter int N   = 2,
  parameter int KT  = 8,
  parameter int P   = 16,
  parameter int KLW = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [KLW-1:0]       k_len,
  input  logic [M*N*4*P-1:0]   c_init,
  output logic                 tile_req_valid,
  input  logic                 tile_req_ready,
  output logic [KLW-1:0]       tile_idx,
  output logic [KT-1:0]        tile_mask,
  output logic [M*N*4*P-1:0]   mm_c,
  input  logic [M*N*4*P-1:0]   mm_d,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [M*N*4*P-1:0]   result,
  output logic                 overflow
);

  localparam int EW = 4 * P;
  localparam int NE = M * N;
  localparam int BW = KLW + 2;
  localparam logic [KLW:0]   KT_M1 = (KLW+1)'(KT - 1);
  localparam logic [KLW:0]   KT_D  = (KLW+1)'(KT);
  localparam logic [KLW:0]   ONE_T = (KLW+1)'(1);
  localparam logic [BW-1:0]  KT_B  = BW'(KT);

  state_t            state_r;
  logic [KLW-1:0]    klen_r;
  logic [KLW:0]      ntiles_r;
  logic [BW-1:0]     base_r;
  elem_t             acc_r [NE];
  elem_t             init_s [NE];
  elem_t             tile_s [NE];
  logic [NE-1:0]     init_ovf_s;
  logic [NE-1:0]     tile_ovf_s;
  logic [KLW:0]      ntiles_s;
  logic [BW-1:0]     base_nxt_s;
  logic              last_s;

  // Lane l of the tile starting at K offset base is live iff base+l < k_len
  function automatic logic [KT-1:0] lane_mask(input logic [BW-1:0] base, input logic [KLW-1:0] kl);
    logic [KT-1:0] m;
    m = {KT{1'b0}};
    for (int l = 0; l < KT; l++) begin
      m[l] = (base + BW'(l)) < {2'b00, kl};
    end
    return m;
  endfunction

  assign ntiles_s   = ({1'b0, k_len} + KT_M1) / KT_D;
  assign base_nxt_s = base_r + KT_B;
  assign last_s     = ({1'b0, tile_idx} == (ntiles_r - ONE_T));

  // Initial accumulator conditioning, checked the same way as every tile result
  always_comb begin
    for (int e = 0; e < NE; e++) begin
      init_ovf_s[e] = out_of_range(c_init[e*EW +: EW]);
`ifdef MATMUL_SAT_EN
      init_s[e] = clamp(c_init[e*EW +: EW]);
`else
      init_s[e] = c_init[e*EW +: EW];
`endif
    end
  end

  for (genvar e = 0; e < NE; e++) begin : g_elem
    matmul_sat_clamp u_clamp (
      .x    (mm_d[e*EW +: EW]),
      .y    (tile_s[e]),
      .flag (tile_ovf_s[e])
    );
    assign mm_c[e*EW +: EW]   = acc_r[e];
    assign result[e*EW +: EW] = acc_r[e];
  end

  // Command FSM: issue a tile, absorb its result the next cycle, repeat until the last tile
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      klen_r         <= '0;
      ntiles_r       <= '0;
      base_r         <= '0;
      tile_idx       <= '0;
      tile_mask      <= '0;
      tile_req_valid <= 1'b0;
      result_valid   <= 1'b0;
      start_ready    <= 1'b1;
      overflow       <= 1'b0;
      for (int e = 0; e < NE; e++) acc_r[e] <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            klen_r      <= k_len;
            ntiles_r    <= ntiles_s;
            base_r      <= '0;
            tile_idx    <= '0;
            overflow    <= |init_ovf_s;
            start_ready <= 1'b0;
            for (int e = 0; e < NE; e++) acc_r[e] <= init_s[e];
            if (k_len == {KLW{1'b0}}) begin
              state_r      <= DONE;
              result_valid <= 1'b1;
              tile_mask    <= '0;
            end else begin
              state_r        <= ISSUE;
              tile_req_valid <= 1'b1;
              tile_mask      <= lane_mask({BW{1'b0}}, k_len);
            end
          end
        end
        ISSUE: begin
          if (tile_req_ready) begin
            tile_req_valid <= 1'b0;
            state_r        <= ACCUM;
          end
        end
        ACCUM: begin
          for (int e = 0; e < NE; e++) acc_r[e] <= tile_s[e];
          overflow <= overflow | (|tile_ovf_s);
          tile_idx <= tile_idx + KLW'(1);
          if (last_s) begin
            state_r      <= DONE;
            result_valid <= 1'b1;
            tile_mask    <= '0;
          end else begin
            state_r        <= ISSUE;
            tile_req_valid <= 1'b1;
            base_r         <= base_nxt_s;
            tile_mask      <= lane_mask(base_nxt_s, klen_r);
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r        <= IDLE;
          tile_req_valid <= 1'b0;
          result_valid   <= 1'b0;
          start_ready    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Scoreboard bench for matmul_tile_sequencer with a behavioural operand buffer + datapath.
// Expected results and tile requests are queued when a command is issued and popped on output.
module tb_matmul_tile_sequencer;

  localparam int M = 2, N = 2, KT = 8, P = 16, KLW = 20;
  localparam int EW = 4 * P;
  localparam int NE = M * N;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct packed {
    logic [NE*EW-1:0] r;
    logic             ovf;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                start_valid;
  logic                start_ready;
  logic [KLW-1:0]      k_len;
  logic [NE*EW-1:0]    c_init;
  logic                tile_req_valid;
  logic                tile_req_ready;
  logic [KLW-1:0]      tile_idx;
  logic [KT-1:0]       tile_mask;
  logic [NE*EW-1:0]    mm_c;
  logic [NE*EW-1:0]    mm_d;
  logic                result_valid;
  logic                result_ready;
  logic [NE*EW-1:0]    result;
  logic                overflow;

  int tests_run = 0;
  int tests_failed = 0;
  exp_t exp_q[$];
  logic [KLW+KT-1:0] tile_q[$];
  longint cin [NE];
  longint opv = 0;
  int cnt_r;

  matmul_tile_sequencer #(.M(M), .N(N), .KT(KT), .P(P), .KLW(KLW)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .k_len(k_len), .c_init(c_init), .tile_req_valid(tile_req_valid),
    .tile_req_ready(tile_req_ready), .tile_idx(tile_idx), .tile_mask(tile_mask),
    .mm_c(mm_c), .mm_d(mm_d), .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand buffer: one-cycle read latency, applies the lane mask; all operands equal opv
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_r <= 0;
    else if (tile_req_valid && tile_req_ready) cnt_r <= $countones(tile_mask);
  end

  always_comb begin
    for (int e = 0; e < NE; e++) begin
      mm_d[e*EW +: EW] = mm_c[e*EW +: EW] + longint'(cnt_r) * opv * opv;
    end
  end

  function automatic longint model_elem(input longint c, input int kl, input longint v, output bit ovf);
    longint acc;
    int cnt;
    ovf = 1'b0;
    acc = c;
    if (acc > SMAX || acc < SMIN) begin
      ovf = 1'b1;
`ifdef MATMUL_SAT_EN
      acc = (acc > SMAX) ? SMAX : SMIN;
`endif
    end
    for (int t = 0; t * KT < kl; t++) begin
      cnt = kl - t * KT;
      if (cnt > KT) cnt = KT;
      acc = acc + longint'(cnt) * v * v;
      if (acc > SMAX || acc < SMIN) begin
        ovf = 1'b1;
`ifdef MATMUL_SAT_EN
        acc = (acc > SMAX) ? SMAX : SMIN;
`endif
      end
    end
    return acc;
  endfunction

  task automatic run_cmd(input int kl, input longint v, input int stall_tile, input int stall_n,
                         input int rr_delay, input bit chk_lat, input bit pulse_start);
    exp_t ex, got_ex;
    bit o, got;
    int ntl, cyc, left, bound;
    logic [KT-1:0] m;
    logic [KLW+KT-1:0] et;
    logic [KLW-1:0] hold_idx;
    logic [KT-1:0] hold_mask;
    logic [NE*EW-1:0] hold_res;
    ex.ovf = 1'b0;
    for (int e = 0; e < NE; e++) begin
      ex.r[e*EW +: EW] = model_elem(cin[e], kl, v, o);
      ex.ovf = ex.ovf | o;
    end
    exp_q.push_back(ex);
    ntl = (kl + KT - 1) / KT;
    for (int t = 0; t < ntl; t++) begin
      for (int l = 0; l < KT; l++) m[l] = (t * KT + l) < kl;
      tile_q.push_back({KLW'(t), m});
    end
    opv = v;
    @(negedge clk);
    tests_run++;
    if (start_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_ready_idle got=%b exp=1", start_ready);
    end
    k_len = KLW'(kl);
    for (int e = 0; e < NE; e++) c_init[e*EW +: EW] = cin[e];
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    cyc = 1; left = stall_n; got = 1'b0; bound = 2 * ntl + stall_n + 20;
    hold_idx = '0; hold_mask = '0;
    while (!got && cyc < bound) begin
      if (result_valid) begin
        got = 1'b1;
      end else begin
        tile_req_ready = 1'b1;
        if (tile_req_valid && tile_idx == KLW'(stall_tile) && left > 0) begin
          if (left == stall_n) begin
            hold_idx = tile_idx; hold_mask = tile_mask;
          end else begin
            tests_run++;
            if (tile_idx !== hold_idx || tile_mask !== hold_mask) begin
              tests_failed++;
              $display("FAIL stall_stable got=%0d/%h exp=%0d/%h", tile_idx, tile_mask, hold_idx, hold_mask);
            end
          end
          left--;
          tile_req_ready = 1'b0;
        end
        if (tile_req_valid && tile_req_ready) begin
          tests_run++;
          if (tile_q.size() == 0) begin
            tests_failed++;
            $display("FAIL tile_unexpected got=%0d/%h exp=none", tile_idx, tile_mask);
          end else begin
            et = tile_q.pop_front();
            if ({tile_idx, tile_mask} !== et) begin
              tests_failed++;
              $display("FAIL tile_req got=%0d/%h exp=%0d/%h", tile_idx, tile_mask,
                       et[KLW+KT-1:KT], et[KT-1:0]);
            end
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    tile_req_ready = 1'b1;
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL result_timeout got=no_result exp=result_within_%0d", bound);
    end
    if (chk_lat) begin
      tests_run++;
      if (cyc != 1 + 2 * ntl) begin
        tests_failed++;
        $display("FAIL latency got=%0d exp=%0d", cyc, 1 + 2 * ntl);
      end
    end
    tests_run++;
    if (tile_q.size() != 0) begin
      tests_failed++;
      $display("FAIL tiles_missing got=%0d_left exp=0", tile_q.size());
      tile_q.delete();
    end
    hold_res = result;
    for (int i = 0; i < rr_delay; i++) begin
      start_valid = (pulse_start && i == 3);
      k_len = KLW'(5);
      @(negedge clk);
      tests_run++;
      if (result !== hold_res || result_valid !== 1'b1 || start_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL done_hold got=%b/%b exp=1/0", result_valid, start_ready);
      end
    end
    start_valid = 1'b0;
    got_ex = exp_q.pop_front();
    for (int e = 0; e < NE; e++) begin
      tests_run++;
      if (result[e*EW +: EW] !== got_ex.r[e*EW +: EW]) begin
        tests_failed++;
        $display("FAIL result[%0d] got=%0d exp=%0d", e, $signed(result[e*EW +: EW]),
                 $signed(got_ex.r[e*EW +: EW]));
      end
    end
    tests_run++;
    if (overflow !== got_ex.ovf) begin
      tests_failed++;
      $display("FAIL overflow got=%b exp=%b", overflow, got_ex.ovf);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    tests_run++;
    if (result_valid !== 1'b0 || start_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL result_release got=%b/%b exp=0/1", result_valid, start_ready);
    end
    if (pulse_start) begin
      repeat (3) @(negedge clk);
      tests_run++;
      if (tile_req_valid !== 1'b0 || result_valid !== 1'b0 || start_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL ignored_start got=%b/%b/%b exp=0/0/1", tile_req_valid, result_valid, start_ready);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    tests_run++;
    if (start_ready !== 1'b1 || tile_req_valid !== 1'b0 || result_valid !== 1'b0 ||
        tile_mask !== '0 || tile_idx !== '0 || overflow !== 1'b0 || mm_c !== '0) begin
      tests_failed++;
      $display("FAIL %s got=sr%b tv%b rv%b m%h i%0d o%b c%0h exp=sr1 tv0 rv0 m0 i0 o0 c0", tag,
               start_ready, tile_req_valid, result_valid, tile_mask, tile_idx, overflow, mm_c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_valid = 1'b0; k_len = '0; c_init = '0;
    tile_req_ready = 1'b1; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("reset");
  endtask

  task automatic test_zero_len();
    cin[0] = 5; cin[1] = -3; cin[2] = 0; cin[3] = 7;
    run_cmd(0, 0, -1, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_partial_tile();
    for (int e = 0; e < NE; e++) cin[e] = 0;
    run_cmd(11, 1, -1, 0, 0, 1'b1, 1'b0);
    cin[0] = 100; cin[1] = -50; cin[2] = 3; cin[3] = -7;
    run_cmd(17, 3, -1, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    for (int e = 0; e < NE; e++) cin[e] = 0;
    run_cmd(11, 1, 1, 5, 0, 1'b0, 1'b0);
  endtask

  task automatic test_done_hold();
    cin[0] = 1; cin[1] = -2; cin[2] = 30; cin[3] = -400;
    run_cmd(11, 2, -1, 0, 10, 1'b1, 1'b1);
  endtask

  task automatic test_init_clamp();
    cin[0] = 64'sd1 <<< 40; cin[1] = -(64'sd1 <<< 35); cin[2] = SMAX; cin[3] = SMIN;
    run_cmd(8, 1, -1, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_accum();
    int n;
    bit hs;
    opv = 3;
    @(negedge clk);
    k_len = KLW'(24); c_init = '0; start_valid = 1'b1; tile_req_ready = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    hs = 1'b0; n = 0;
    while (!hs && n < 10) begin
      hs = tile_req_valid && tile_req_ready;
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!hs) begin
      tests_failed++;
      $display("FAIL accum_reach got=no_handshake exp=handshake");
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("reset_mid_accum");
    rst_n = 1'b1;
    for (int e = 0; e < NE; e++) cin[e] = 10 * e;
    run_cmd(9, 1, -1, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_long_k();
    for (int e = 0; e < NE; e++) cin[e] = 127;
    run_cmd(134000, 127, -1, 0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_partial_tile();
    test_stall();
    test_done_hold();
    test_init_clamp();
    test_reset_mid_accum();
    test_long_k();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
